// File: rtl/i2s_tx_multi.sv
// I2S / left-justified / TDM serial audio transmitter. It has a one-frame holding
// buffer with a valid/ready handshake, and it reports an underrun when the buffer is empty.
module i2s_tx_multi #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         I2S_BCK,
  output logic                         I2S_LRCK,
  output logic                         I2S_DATA,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int FRAME_BITS = CHANNELS * SLOT_W;
  localparam int FRAME_W    = CHANNELS * SAMPLE_W;
  localparam int D_W        = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [D_W-1:0]     d;
  logic [D_W-1:0]     d_nxt;
  logic               hold_empty;
  logic [FRAME_W-1:0] hold_data;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_nxt;
  logic               div_wrap;
  logic               fall;
  logic               load;
  logic               take;

  // Serial bit for frame position dv: MSB first within each slot, zero-padded after the LSB.
  function automatic logic frame_bit(input logic [FRAME_W-1:0] f, input logic [D_W-1:0] dv);
    int pos;
    int slot;
    int idx;
    logic [FRAME_W-1:0] sh;
    pos  = int'(dv);
    slot = pos / SLOT_W;
    idx  = pos % SLOT_W;
    if (idx < SAMPLE_W) begin
      sh = f >> (slot * SAMPLE_W + SAMPLE_W - 1 - idx);
      return sh[0];
    end
    return 1'b0;
  endfunction

  // In I2S mode the word select looks one bit ahead, so it leads the slot MSB by one BCK.
  function automatic logic lrck_bit(input logic [D_W-1:0] dv);
    int pos;
    pos = int'(dv);
    if (MODE == 0) pos = (pos + 1) % FRAME_BITS;
    return (pos >= FRAME_BITS / 2);
  endfunction

  assign div_wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall         = div_wrap & I2S_BCK;
  assign load         = fall & (d == D_W'(FRAME_BITS - 1));
  assign take         = sample_valid & hold_empty;
  assign d_nxt        = (d == D_W'(FRAME_BITS - 1)) ? '0 : d + 1'b1;
  assign frame_nxt    = (load && !hold_empty) ? hold_data : frame;
  assign sample_ready = hold_empty;

  // Holding data needs no reset; its validity is tracked by hold_empty.
  always_ff @(posedge clk) begin
    if (take) hold_data <= sample_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      I2S_BCK     <= 1'b0;
      I2S_LRCK    <= 1'b0;
      I2S_DATA    <= 1'b0;
      d           <= '0;
      hold_empty  <= 1'b1;
      frame       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        I2S_BCK <= ~I2S_BCK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // Data and word select change only on the falling BCK event; the new frame is visible at d=0.
      if (fall) begin
        d        <= d_nxt;
        I2S_DATA <= frame_bit(frame_nxt, d_nxt);
        I2S_LRCK <= lrck_bit(d_nxt);
      end
      if (load) begin
        frame_start <= 1'b1;
        frame       <= frame_nxt;
        if (hold_empty) underrun <= 1'b1;
      end
      // A same-cycle accept and load never collide: accept needs empty, draining needs full.
      if (take) hold_empty <= 1'b0;
      else if (load && !hold_empty) hold_empty <= 1'b1;
    end
  end

endmodule
